// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_pkg
//  Purpose  : Shared HUB75 panel-bus bit map and scan FSM encoding.
//  Revision : 1.0  initial release
// ============================================================================
package hub75_pkg;

    // LED_PANEL bit positions
    localparam int R0       = 0;
    localparam int G0       = 1;
    localparam int B0       = 2;
    localparam int R1       = 3;
    localparam int G1       = 4;
    localparam int B1       = 5;
    localparam int ADDR_LSB = 6;
    localparam int ADDR_W   = 5;
    localparam int PCLK     = 11;
    localparam int LATCH    = 12;
    localparam int OE_N     = 13;

    localparam int PH_W     = 2;

    typedef enum logic [1:0] {
        ST_SHIFT = 2'd0,
        ST_BLANK = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/led_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_scanner_if
//  Purpose  : Scanner <-> painter bus: pixel coordinates out, colour back.
//  Revision : 1.0  initial release
// ============================================================================
interface led_scanner_if;

    logic [12:0] frame;
    logic [7:0]  subframe;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [2:0]  rgb;

    modport master (
        output frame,
        output subframe,
        output x,
        output y,
        input  rgb
    );

    modport slave (
        input  frame,
        input  subframe,
        input  x,
        input  y,
        output rgb
    );

endinterface : led_scanner_if
`default_nettype wire

// File: rtl/led_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : led_scanner
//  Purpose  : HUB75 1/32-scan sequencer; walks each row pair, samples the
//             painter and shifts/latches the data into the panel.
//  Revision : 1.0  initial release
// ============================================================================
module led_scanner
    import hub75_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int HALF_ROWS = 32,
    parameter int SUBFRAMES = 8
) (
    input  wire logic      clk,
    input  wire logic      resetn,
    led_scanner_if.master  paint,
    output logic [15:0]    LED_PANEL
);

    localparam logic [5:0] c_LAST_COL = 6'(WIDTH - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(HALF_ROWS - 1);
    localparam logic [7:0] c_LAST_SUB = 8'(SUBFRAMES - 1);
    localparam logic [5:0] c_Y_OFS    = 6'(HALF_ROWS);

    state_t            r_state;
    logic [5:0]        r_col;
    logic [PH_W-1:0]   r_phase;
    logic [4:0]        r_row;
    logic [7:0]        r_subframe;
    logic [12:0]       r_frame;
    logic [5:0]        r_x;
    logic [5:0]        r_y;
    logic [2:0]        r_top;
    logic [5:0]        r_data;
    logic [4:0]        r_addr;
    logic              r_pclk;
    logic              r_latch;
    logic              r_oe_n;
    logic              r_shown_valid;

    state_t            w_state;
    logic [5:0]        w_col;
    logic [PH_W-1:0]   w_phase;
    logic [4:0]        w_row;
    logic [7:0]        w_subframe;
    logic [12:0]       w_frame;
    logic [5:0]        w_x;
    logic [5:0]        w_y;
    logic [2:0]        w_top;
    logic [5:0]        w_data;
    logic [4:0]        w_addr;
    logic              w_pclk;
    logic              w_latch;
    logic              w_oe_n;
    logic              w_shown_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_SHIFT;
            r_col         <= '0;
            r_phase       <= '0;
            r_row         <= '0;
            r_subframe    <= '0;
            r_frame       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_top         <= '0;
            r_data        <= '0;
            r_addr        <= '0;
            r_pclk        <= 1'b0;
            r_latch       <= 1'b0;
            r_oe_n        <= 1'b1;
            r_shown_valid <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_col         <= w_col;
            r_phase       <= w_phase;
            r_row         <= w_row;
            r_subframe    <= w_subframe;
            r_frame       <= w_frame;
            r_x           <= w_x;
            r_y           <= w_y;
            r_top         <= w_top;
            r_data        <= w_data;
            r_addr        <= w_addr;
            r_pclk        <= w_pclk;
            r_latch       <= w_latch;
            r_oe_n        <= w_oe_n;
            r_shown_valid <= w_shown_valid;
        end
    end

    // Each transition computes the register values of the cycle being entered,
    // so every output is stable for the whole cycle of its phase.
    always_comb begin
        w_state       = r_state;
        w_col         = r_col;
        w_phase       = r_phase;
        w_row         = r_row;
        w_subframe    = r_subframe;
        w_frame       = r_frame;
        w_x           = r_x;
        w_y           = r_y;
        w_top         = r_top;
        w_data        = r_data;
        w_addr        = r_addr;
        w_pclk        = r_pclk;
        w_latch       = r_latch;
        w_oe_n        = r_oe_n;
        w_shown_valid = r_shown_valid;

        case (r_state)
            ST_SHIFT: begin
                case (r_phase)
                    2'd0: begin
                        w_phase = 2'd1;
                        w_y     = 6'(r_row) + c_Y_OFS;
                        w_top   = paint.rgb;
                    end
                    2'd1: begin
                        w_phase = 2'd2;
                        w_data  = {paint.rgb, r_top};
                        w_pclk  = 1'b0;
                    end
                    2'd2: begin
                        w_phase = 2'd3;
                        w_pclk  = 1'b1;
                    end
                    default: begin
                        w_phase = 2'd0;
                        w_pclk  = 1'b0;
                        if (r_col == c_LAST_COL) begin
                            w_state = ST_BLANK;
                            w_oe_n  = 1'b1;
                            w_addr  = r_row;
                        end else begin
                            w_col = r_col + 6'd1;
                            w_x   = r_col + 6'd1;
                            w_y   = 6'(r_row);
                        end
                    end
                endcase
            end

            ST_BLANK: begin
                w_state       = ST_LATCH;
                w_latch       = 1'b1;
                w_oe_n        = 1'b1;
                w_shown_valid = 1'b1;
            end

            ST_LATCH: begin
                w_state = ST_SHIFT;
                w_latch = 1'b0;
                w_col   = '0;
                w_phase = '0;
                w_x     = '0;
                w_oe_n  = ~r_shown_valid;
                // Frame counters only move here, so a row never mixes subframes
                if (r_row == c_LAST_ROW) begin
                    w_row = '0;
                    if (r_subframe == c_LAST_SUB) begin
                        w_subframe = '0;
                        w_frame    = r_frame + 13'd1;
                    end else begin
                        w_subframe = r_subframe + 8'd1;
                    end
                end else begin
                    w_row = r_row + 5'd1;
                end
                w_y = 6'(w_row);
            end

            default: begin
                w_state = ST_SHIFT;
                w_col   = '0;
                w_phase = '0;
            end
        endcase
    end

    assign paint.frame    = r_frame;
    assign paint.subframe = r_subframe;
    assign paint.x        = r_x;
    assign paint.y        = r_y;

    always_comb begin
        LED_PANEL                       = '0;
        LED_PANEL[B0:R0]                = r_data[2:0];
        LED_PANEL[B1:R1]                = r_data[5:3];
        LED_PANEL[ADDR_LSB +: ADDR_W]   = r_addr;
        LED_PANEL[PCLK]                 = r_pclk;
        LED_PANEL[LATCH]                = r_latch;
        LED_PANEL[OE_N]                 = r_oe_n;
    end

endmodule : led_scanner
`default_nettype wire

// File: tb/tb_led_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_scanner
//  Purpose  : Self-checking bench for led_scanner (full size plus a tiny
//             instance that reaches the 13-bit frame wrap quickly).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_scanner;

    logic        clk;
    logic        resetn;
    logic [15:0] panel;
    logic [15:0] panel_s;

    led_scanner_if pif ();
    led_scanner_if pif_s ();

    // Painter model: top half 101, bottom half 010
    assign pif.rgb   = (pif.y < 6'd32) ? 3'b101 : 3'b010;
    assign pif_s.rgb = 3'b000;

    led_scanner #(.WIDTH(64), .HALF_ROWS(32), .SUBFRAMES(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .paint     (pif.master),
        .LED_PANEL (panel)
    );

    led_scanner #(.WIDTH(1), .HALF_ROWS(1), .SUBFRAMES(1)) dut_small (
        .clk       (clk),
        .resetn    (resetn),
        .paint     (pif_s.master),
        .LED_PANEL (panel_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pclk_rises, latch_cnt, oe_low, sub_mid;
    logic prev_pclk;
    logic [7:0] prev_sub;
    bit small_done = 0;

    typedef struct {
        int          cyc;
        bit          chk_xy;
        logic [5:0]  x;
        logic [5:0]  y;
        logic [15:0] panel;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (cyc < 258) begin
            if (panel[11] && !prev_pclk) pclk_rises++;
            if (panel[12]) latch_cnt++;
            if (!panel[13]) oe_low++;
        end
        if (pif.subframe != prev_sub && (cyc % 258) != 0) sub_mid++;
        prev_pclk = panel[11];
        prev_sub  = pif.subframe;
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        cyc        = 0;
        pclk_rises = 0;
        latch_cnt  = 0;
        oe_low     = 0;
        sub_mid    = 0;
        prev_pclk  = panel[11];
        prev_sub   = pif.subframe;
        monitor();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Frame wrap on the tiny instance: one frame is 6 cycles there
    initial begin : small_wrap
        int waited;
        bit found;
        wait (resetn === 1'b1);
        found = 0;
        for (int i = 0; i < 60000 && !found; i++) begin
            @(negedge clk);
            if (pif_s.frame == 13'h1fff) found = 1;
        end
        check("small_reach_8191", 32'(found), 32'd1);
        if (found) begin
            waited = 0;
            while (pif_s.frame == 13'h1fff && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("wrap_frame", 32'(pif_s.frame), 32'd0);
            check("wrap_subframe", 32'(pif_s.subframe), 32'd0);
            check("wrap_hold_cycles", 32'(waited), 32'd6);
        end
        small_done = 1;
    end

    initial begin : main
        vecs[0]  = '{0,   1'b1, 6'd0,  6'd0,  16'h2000};
        vecs[1]  = '{1,   1'b1, 6'd0,  6'd32, 16'h2000};
        vecs[2]  = '{2,   1'b1, 6'd0,  6'd32, 16'h2015};
        vecs[3]  = '{3,   1'b1, 6'd0,  6'd32, 16'h2815};
        vecs[4]  = '{4,   1'b1, 6'd1,  6'd0,  16'h2015};
        vecs[5]  = '{7,   1'b1, 6'd1,  6'd32, 16'h2815};
        vecs[6]  = '{255, 1'b1, 6'd63, 6'd32, 16'h2815};
        vecs[7]  = '{256, 1'b0, 6'd0,  6'd0,  16'h2015};
        vecs[8]  = '{257, 1'b0, 6'd0,  6'd0,  16'h3015};
        vecs[9]  = '{258, 1'b1, 6'd0,  6'd1,  16'h0015};
        vecs[10] = '{259, 1'b1, 6'd0,  6'd33, 16'h0015};
        vecs[11] = '{261, 1'b1, 6'd0,  6'd33, 16'h0815};
        vecs[12] = '{514, 1'b0, 6'd0,  6'd0,  16'h2055};
        vecs[13] = '{515, 1'b0, 6'd0,  6'd0,  16'h3055};
        vecs[14] = '{516, 1'b1, 6'd0,  6'd2,  16'h0055};

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_panel", 32'(panel), 32'h2000);
        check("rst_frame", 32'(pif.frame), 32'd0);
        check("rst_subframe", 32'(pif.subframe), 32'd0);
        check("rst_xy", {20'd0, pif.x, pif.y}, 32'd0);

        release_reset();
        for (int i = 0; i < 15; i++) begin
            run_to(vecs[i].cyc);
            check($sformatf("vec%0d_panel", i), 32'(panel), 32'(vecs[i].panel));
            if (vecs[i].chk_xy) begin
                check($sformatf("vec%0d_x", i), 32'(pif.x), 32'(vecs[i].x));
                check($sformatf("vec%0d_y", i), 32'(pif.y), 32'(vecs[i].y));
            end
        end
        check("row0_pclk_rises", 32'(pclk_rises), 32'd64);
        check("row0_latch_cycles", 32'(latch_cnt), 32'd1);
        check("row0_oe_low_cycles", 32'(oe_low), 32'd0);

        run_to(8255);
        check("sf_before_wrap", 32'(pif.subframe), 32'd0);
        run_to(8256);
        check("sf_after_row31", 32'(pif.subframe), 32'd1);
        check("frame_after_row31", 32'(pif.frame), 32'd0);
        check("y_after_row31", 32'(pif.y), 32'd0);
        run_to(66047);
        check("sf_last", 32'(pif.subframe), 32'd7);
        check("frame_before_66048", 32'(pif.frame), 32'd0);
        run_to(66048);
        check("sf_frame_wrap", 32'(pif.subframe), 32'd0);
        check("frame_after_66048", 32'(pif.frame), 32'd1);
        check("sf_mid_row_changes", 32'(sub_mid), 32'd0);

        // Asynchronous reset mid-row (row 5, column 20, phase 2)
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        run_to(5 * 258 + 20 * 4 + 2);
        check("r5c20_x", 32'(pif.x), 32'd20);
        check("r5c20_y", 32'(pif.y), 32'd37);
        check("r5c20_panel", 32'(panel), 32'h0115);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_panel", 32'(panel), 32'h2000);
        check("async_xy", {20'd0, pif.x, pif.y}, 32'd0);
        check("async_frame_sf", {11'd0, pif.frame, pif.subframe}, 32'd0);
        release_reset();
        check("rerun_xy", {20'd0, pif.x, pif.y}, 32'd0);
        run_to(258);
        check("rerun_oe_low_row0", 32'(oe_low), 32'd0);
        check("rerun_y_row1", 32'(pif.y), 32'd1);
        check("rerun_oe_row1", 32'(panel[13]), 32'd0);

        for (int i = 0; i < 1000 && !small_done; i++) @(posedge clk);
        check("small_checker_done", 32'(small_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_led_scanner
`default_nettype wire
